sort_seq_ctrl: RTL and testbench

- Sequential sort engine and controller for the 8-lane, 4-bit packed sort datapath.
- Accepts one packed vector per valid/ready handshake and runs an odd-even transposition sort, one compare-swap phase per clock, using parallel compare-exchange cells.
- Presents the sorted vector on a valid/ready output and holds it until the downstream consumer takes it.

---
 rtl/sort_seq_ctrl.sv | 109 ++++++++++
 tb/tb_sort_seq_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sort_seq_ctrl.sv
// Sequential odd-even transposition sort engine with valid/ready input and output.
// One compare-exchange phase per clock; the result is held until the consumer takes it.
module sort_seq_ctrl #(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic          descend,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N*W-1:0] out_data,
    output logic          busy,
    output logic [CW-1:0] sort_count
);

    localparam int PW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [PW-1:0]  phase;
    logic           dir;
    logic [W-1:0]   elem    [N];
    logic [W-1:0]   swapped [N];
    logic [N*W-1:0] next_data;

    // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)... so pairs never overlap.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elem[i] = out_data[(N-1-i)*W +: W];
        end
        swapped = elem;
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == phase[0]) begin
                if (dir ? (elem[i] < elem[i+1]) : (elem[i] > elem[i+1])) begin
                    swapped[i]   = elem[i+1];
                    swapped[i+1] = elem[i];
                end
            end
        end
        next_data = '0;
        for (int i = 0; i < N; i++) begin
            next_data[(N-1-i)*W +: W] = swapped[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_data   <= '0;
            phase      <= '0;
            dir        <= 1'b0;
            sort_count <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        out_data <= in_data;
                        dir      <= descend;
                        phase    <= '0;
                        state    <= SORT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SORT: begin
                    out_data <= next_data;
                    // N phases always run, so latency never depends on the data.
                    if (phase == PW'(N - 1)) begin
                        phase     <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        sort_count <= sort_count + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl with a cycle-level behavioural model checked every cycle.
// A second instance with CW=2 observes the same traffic to exercise counter wrap.
module tb_sort_seq_ctrl;

    localparam int N = 8;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic           descend = 1'b0;
    logic           out_ready = 1'b0;
    logic           in_ready, out_valid, busy;
    logic           in_ready2, out_valid2, busy2;
    logic [N*W-1:0] out_data, out_data2;
    logic [7:0]     count8;
    logic [1:0]     count2;

    int total = 0;
    int bad = 0;

    // Model: 0 idle, 1 sorting, 2 done.
    int             mstate = 0;
    int             mleft = 0;
    int             mcount = 0;
    logic [N*W-1:0] mout = '0;
    logic [N*W-1:0] mresult = '0;

    always #5 clk = ~clk;

    sort_seq_ctrl #(.N(N), .W(W), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .descend(descend), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .sort_count(count8)
    );

    sort_seq_ctrl #(.N(N), .W(W), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .descend(descend), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .busy(busy2), .sort_count(count2)
    );

    function automatic logic [N*W-1:0] sortVec(input logic [N*W-1:0] v, input logic desc);
        int a [N];
        int t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) a[i] = int'(v[(N-1-i)*W +: W]);
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < N; i++) r[(N-1-i)*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each edge from the stable inputs, then outputs are compared 2ns later.
    always @(posedge clk) begin
        if (!rst_n) begin
            mstate = 0; mleft = 0; mcount = 0; mout = '0;
        end else begin
            case (mstate)
                0: if (in_valid) begin
                    mresult = sortVec(in_data, descend);
                    mleft = N;
                    mstate = 1;
                end
                1: begin
                    mleft--;
                    if (mleft == 0) begin
                        mstate = 2;
                        mout = mresult;
                    end
                end
                default: if (out_ready) begin
                    mstate = 0;
                    mcount++;
                end
            endcase
        end
        #2;
        if (rst_n) begin
            checkOutput("model_in_ready", 64'(in_ready), 64'(mstate == 0));
            checkOutput("model_out_valid", 64'(out_valid), 64'(mstate == 2));
            checkOutput("model_busy", 64'(busy), 64'(mstate != 0));
            checkOutput("model_count8", 64'(count8), 64'(mcount % 256));
            checkOutput("model_count2", 64'(count2), 64'(mcount % 4));
            checkOutput("model_out_valid2", 64'(out_valid2), 64'(mstate == 2));
            if (mstate != 1) begin
                checkOutput("model_out_data", 64'(out_data), 64'(mout));
                checkOutput("model_out_data2", 64'(out_data2), 64'(mout));
            end
        end
    end

    task automatic waitResult(output int lat);
        lat = 0;
        checkOutput("no_early_valid", 64'(out_valid), 64'd0);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [N*W-1:0] vec, input logic desc, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = vec;
        descend = desc;
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(lat);
    endtask

    task automatic deliver(input string name, input logic [N*W-1:0] exp,
                           input int cnt8, input int cnt2);
        checkOutput({name, "_data"}, 64'(out_data), 64'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({name, "_count8"}, 64'(count8), 64'(cnt8));
        checkOutput({name, "_count2"}, 64'(count2), 64'(cnt2));
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_count", 64'(count8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'h52EBF376, 1'b0, lat);
        checkOutput("asc_latency", 64'(lat), 64'd8);
        deliver("asc", 32'h23567BEF, 1, 1);

        applyStimulus(32'h52EBF376, 1'b1, lat);
        checkOutput("desc_latency", 64'(lat), 64'd8);
        deliver("desc", 32'hFEB76532, 2, 2);

        applyStimulus(32'hFEDCBA98, 1'b0, lat);
        checkOutput("worst_latency", 64'(lat), 64'd8);
        deliver("worst", 32'h89ABCDEF, 3, 3);

        applyStimulus(32'h330F03F0, 1'b0, lat);
        checkOutput("dup_latency", 64'(lat), 64'd8);
        deliver("dup", 32'h000333FF, 4, 0);

        // Backpressure with a competing input that must be ignored.
        applyStimulus(32'h52EBF376, 1'b0, lat);
        checkOutput("bp_latency", 64'(lat), 64'd8);
        in_valid = 1'b1;
        in_data = 32'h11111111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", 64'(out_data), 64'h23567BEF);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        in_data = 32'hFEDCBA98;
        descend = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_count8", 64'(count8), 64'd5);
        checkOutput("bp_count2", 64'(count2), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b_accepted_busy", 64'(busy), 64'd1);
        checkOutput("b2b_in_ready", 64'(in_ready), 64'd0);
        waitResult(lat);
        checkOutput("b2b_latency", 64'(lat), 64'd8);
        deliver("b2b", 32'h89ABCDEF, 6, 2);

        // Asynchronous reset in the middle of a sort.
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 32'h52EBF376;
        descend = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_data", 64'(out_data), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_count", 64'(count8), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'h330F03F0, 1'b1, lat);
        checkOutput("fresh_latency", 64'(lat), 64'd8);
        deliver("fresh", 32'hFF333000, 1, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
